rom_stream_reader: RTL and testbench
====================================

ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of ROM word and stream data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, width of ROM address, base and length.
REQ-003 SHALL have parameter ROM_LATENCY, default 1, cycles from address to data; only 1 or 2 are legal.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer words; power of two, at least ROM_LATENCY+1.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a burst.
REQ-008 SHALL have port base_addr, input, ADDR_WIDTH, first ROM address, sampled with start.
REQ-009 SHALL have port length, input, ADDR_WIDTH, burst word count minus one, sampled with start.
REQ-010 SHALL have port rom_addr, output, ADDR_WIDTH, registered address to the ROM.
REQ-011 SHALL have port rom_data, input, DATA_WIDTH, ROM read data.
REQ-012 SHALL have ports m_data (DATA_WIDTH), m_valid (1), m_last (1), outputs; m_ready (1), input: the stream interface.
REQ-013 SHALL have ports busy, output, 1, burst in progress; done, output, 1, one-cycle completion pulse.

Function
REQ-014 SHALL use FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN after the last address is issued; DRAIN->IDLE when the last word is accepted.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL load rom_addr=base_addr at the edge sampling start; that address is issued in the first RUN cycle.
REQ-017 SHALL issue one address per RUN cycle only if (FIFO occupancy + reads in flight) < FIFO_DEPTH, incrementing rom_addr by one per issue, modulo 2^ADDR_WIDTH.
REQ-018 SHALL issue exactly length+1 addresses per burst; length=2^ADDR_WIDTH-1 reads the entire ROM.
REQ-019 SHALL track in-flight reads with a ROM_LATENCY-deep valid pipeline and write rom_data into the FIFO in the cycle rom_data is valid for an issued address.
REQ-020 SHALL never drop or duplicate a word; the FIFO SHALL never overflow under any m_ready pattern.
REQ-021 SHALL present m_valid high from the cycle after a word is written and hold m_data/m_last stable until m_valid and m_ready are both high.
REQ-022 SHALL permit simultaneous FIFO write and read in one cycle, including when full (read frees space) or empty (no bypass).
REQ-023 SHALL assert m_last with the final word of the burst only.
REQ-024 SHALL assert done for exactly one cycle, the cycle after the last word handshake; busy SHALL drop in that same cycle.
REQ-025 SHALL assert busy in RUN and DRAIN; start accepted in the done cycle begins a new burst.
REQ-026 SHALL deliver the first word with m_valid high at cycle 2+ROM_LATENCY after the start cycle (cycle 0), given m_ready=1.
REQ-027 SHALL sustain one word per cycle when m_ready is held high.

Reset
REQ-028 SHALL on rst enter IDLE and clear rom_addr, m_data, m_valid, m_last, busy, done to 0.
REQ-029 SHALL on rst mid-burst flush the FIFO and discard in-flight reads; no stale word SHALL appear after reset.
REQ-030 SHALL give rst priority over start in the same cycle.

Configuration
REQ-031 SHALL, when macro ROM_STREAM_READER_LOOP_EN is defined, add input port loop (1 bit); with loop=1 at burst end the reader restarts from the sampled base_addr without entering IDLE, m_last marks each pass end, and done pulses only after loop is seen 0 at a pass end.
REQ-032 SHALL, without ROM_STREAM_READER_LOOP_EN, omit port loop and behave as loop=0.

Verification
REQ-033 SHALL test: ROM_LATENCY=1, base=0x10, length=3, m_ready=1 -> data of 0x10..0x13, first m_valid at cycle 3, m_last on 0x13, done one cycle later.
REQ-034 SHALL test: ROM_LATENCY=2, base=0xFE, length=3 -> addresses 0xFE,0xFF,0x00,0x01 in order, first m_valid at cycle 4.
REQ-035 SHALL test: length=15, m_ready toggled randomly and held low 10 cycles -> all 16 words in order, rom_addr stalls, no loss or duplication.
REQ-036 SHALL test: rst asserted with 3 words buffered -> next cycle m_valid=0, busy=0; new burst returns only new data.
REQ-037 SHALL test: start pulsed while busy -> ignored; start in done cycle -> second burst starts immediately.
REQ-038 SHALL test with ROM_STREAM_READER_LOOP_EN: length=1, loop=1 for 3 passes -> words base,base+1 repeated, m_last per pass, done once.

Source files
------------

// File: rtl/rom_stream_reader.sv
// Streams a contiguous ROM burst (base_addr .. base_addr+length) out through a
// small ready/valid FIFO. Optional pass looping is enabled by ROM_STREAM_READER_LOOP_EN.
module rom_stream_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int ROM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
`ifdef ROM_STREAM_READER_LOOP_EN
  input  logic                  loop,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [ROM_LATENCY-1:0]  r_vld_p;
  logic [ROM_LATENCY-1:0]  r_lst_p;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   r_mem_last;
  logic [PTR_W:0]          r_wptr;
  logic [PTR_W:0]          r_rptr;
  logic                    r_done;

  logic [PTR_W:0]          w_occ;
  logic [PTR_W:0]          w_infl;
  logic [PTR_W+1:0]        w_used;
  logic                    w_space;
  logic                    w_issue;
  logic                    w_last_issue;
  logic                    w_accept;
  logic                    w_restart;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_final_rd;
  logic                    w_loop;
  logic [ADDR_WIDTH-1:0]   w_rbase;
  logic [ADDR_WIDTH-1:0]   w_rlen;

`ifdef ROM_STREAM_READER_LOOP_EN
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_len;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_base <= base_addr;
      r_len  <= length;
    end
  end

  assign w_loop  = loop;
  assign w_rbase = r_base;
  assign w_rlen  = r_len;
`else
  assign w_loop  = 1'b0;
  assign w_rbase = base_addr;
  assign w_rlen  = length;
`endif

  always_comb begin
    w_infl = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      w_infl = w_infl + (PTR_W+1)'(r_vld_p[i]);
    end
  end

  // Credit check counts words already buffered plus reads still in the ROM
  assign w_occ      = r_wptr - r_rptr;
  assign w_used     = {1'b0, w_occ} + {1'b0, w_infl};
  assign w_space    = (w_used < (PTR_W+2)'(FIFO_DEPTH));
  assign m_valid    = (w_occ != '0);
  assign w_rd       = m_valid & m_ready;
  assign w_wr       = r_vld_p[ROM_LATENCY-1];
  assign m_data     = m_valid ? r_mem[r_rptr[PTR_W-1:0]] : '0;
  assign m_last     = m_valid & r_mem_last[r_rptr[PTR_W-1:0]];
  // Earlier pass-end words may still be queued; only the very last word ends the burst
  assign w_final_rd = w_rd & m_last & (w_occ == (PTR_W+1)'(1)) & (w_infl == '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_last_issue = 1'b0;
    w_accept     = 1'b0;
    w_restart    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_space) begin
          w_issue = 1'b1;
          if (r_cnt == '0) begin
            w_last_issue = 1'b1;
            if (w_loop) w_restart   = 1'b1;
            else        w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_final_rd) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_vld_p <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == DRAIN) && w_final_rd;
      if (w_accept) begin
        r_addr <= base_addr;
        r_cnt  <= length;
      end else if (w_restart) begin
        r_addr <= w_rbase;
        r_cnt  <= w_rlen;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_cnt  <= r_cnt - ADDR_WIDTH'(1);
      end
      // ROM read pipeline: stage 0 is the cycle after the address is issued
      r_vld_p[0] <= w_issue;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end
      if (w_wr) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    r_lst_p[0] <= w_last_issue;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      r_lst_p[i] <= r_lst_p[i-1];
    end
    // FIFO write stage: rom_data is valid for the oldest in-flight read
    if (w_wr) begin
      r_mem[r_wptr[PTR_W-1:0]]      <= rom_data;
      r_mem_last[r_wptr[PTR_W-1:0]] <= r_lst_p[ROM_LATENCY-1];
    end
  end

  assign rom_addr = r_addr;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: one instance with ROM latency 1 and one with latency 2
// share stimulus; a queue scoreboard holds the words each burst must deliver.
module tb_rom_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start1, start2, m_ready;
  logic [7:0]  base, len;
  logic [7:0]  addr1, addr2;
  logic [15:0] rd1, rd2, r2a, md1, md2;
  logic        mv1, mv2, ml1, ml2, busy1, busy2, done1, done2;
`ifdef ROM_STREAM_READER_LOOP_EN
  logic        loop;
`endif

  typedef struct packed { logic [15:0] d; logic l; } exp_t;
  typedef struct {
    logic [7:0] base;
    logic [7:0] len;
    int         rmode;
    int         fv1, fv2, dn1, dn2;
  } vec_t;

  exp_t q1[$];
  exp_t q2e[$];
  exp_t e1, e2;
  int   n_checks = 0;
  int   n_err    = 0;
  int   dcnt1    = 0;
  int   dcnt2    = 0;

  rom_stream_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .ROM_LATENCY(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base), .length(len),
`ifdef ROM_STREAM_READER_LOOP_EN
    .loop(loop),
`endif
    .rom_addr(addr1), .rom_data(rd1), .m_data(md1), .m_valid(mv1), .m_last(ml1),
    .m_ready(m_ready), .busy(busy1), .done(done1)
  );

  rom_stream_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .ROM_LATENCY(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base), .length(len),
`ifdef ROM_STREAM_READER_LOOP_EN
    .loop(loop),
`endif
    .rom_addr(addr2), .rom_data(rd2), .m_data(md2), .m_valid(mv2), .m_last(ml2),
    .m_ready(m_ready), .busy(busy2), .done(done2)
  );

  function automatic logic [15:0] rom_val(input logic [7:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  // ROM models: latency 1 and latency 2
  always @(posedge clk) rd1 <= rom_val(addr1);
  always @(posedge clk) begin
    r2a <= rom_val(addr2);
    rd2 <= r2a;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void push_burst(input logic [7:0] b, input logic [7:0] l, input logic [1:0] m);
    exp_t e;
    for (int k = 0; k <= int'(l); k++) begin
      e.d = rom_val(b + 8'(k));
      e.l = (k == int'(l));
      if (m[0]) q1.push_back(e);
      if (m[1]) q2e.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        p1_stall = 1'b0, p2_stall = 1'b0;
  logic [15:0] p1_d, p2_d;

  always @(negedge clk) begin
    if (rst) begin
      p1_stall = 1'b0;
      p2_stall = 1'b0;
    end else begin
      if (p1_stall) begin
        chk("hold_valid1", 32'(mv1), 32'd1);
        chk("hold_data1", 32'(md1), 32'(p1_d));
      end
      if (p2_stall) begin
        chk("hold_valid2", 32'(mv2), 32'd1);
        chk("hold_data2", 32'(md2), 32'(p2_d));
      end
      if (mv1 && m_ready) begin
        if (q1.size() == 0) chk("extra_word1", 32'(md1), 32'hFFFF_FFFF);
        else begin
          e1 = q1.pop_front();
          chk("data1", 32'(md1), 32'(e1.d));
          chk("last1", 32'(ml1), 32'(e1.l));
        end
      end
      if (mv2 && m_ready) begin
        if (q2e.size() == 0) chk("extra_word2", 32'(md2), 32'hFFFF_FFFF);
        else begin
          e2 = q2e.pop_front();
          chk("data2", 32'(md2), 32'(e2.d));
          chk("last2", 32'(ml2), 32'(e2.l));
        end
      end
      if (done1) dcnt1++;
      if (done2) dcnt2++;
      p1_stall = mv1 && !m_ready;
      p2_stall = mv2 && !m_ready;
      p1_d = md1;
      p2_d = md2;
    end
  end

  // rmode: 0 = ready held high, 1 = random ready, 2 = random ready with cycles 8..17 held low
  task automatic do_burst(input logic [7:0] b, input logic [7:0] l, input int rmode,
                          input int efv1, input int efv2, input int edn1, input int edn2);
    int fv1 = -1, fv2 = -1, dn1 = -1, dn2 = -1;
    int d01 = dcnt1, d02 = dcnt2;
    logic [7:0] a13_1 = '0, a13_2 = '0;
    push_burst(b, l, 2'b11);
    base = b; len = l; start1 = 1'b1; start2 = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 600 && (dn1 < 0 || dn2 < 0); c++) begin
      if (c > 0) begin
        start1 = 1'b0; start2 = 1'b0;
        if (rmode == 1)      m_ready = 1'($urandom_range(0, 1));
        else if (rmode == 2) m_ready = (c >= 8 && c < 18) ? 1'b0 : 1'($urandom_range(0, 1));
        else                 m_ready = 1'b1;
      end
      if (mv1 && fv1 < 0) fv1 = c;
      if (mv2 && fv2 < 0) fv2 = c;
      if (done1 && dn1 < 0) begin dn1 = c; chk("busy_at_done1", 32'(busy1), 32'd0); end
      if (done2 && dn2 < 0) begin dn2 = c; chk("busy_at_done2", 32'(busy2), 32'd0); end
      if (rmode == 2 && c == 13) begin a13_1 = addr1; a13_2 = addr2; end
      if (rmode == 2 && c == 17) begin
        chk("addr_stall1", 32'(addr1), 32'(a13_1));
        chk("addr_stall2", 32'(addr2), 32'(a13_2));
      end
      tick();
    end
    m_ready = 1'b1;
    chk("done_seen1", 32'(dn1 >= 0), 32'd1);
    chk("done_seen2", 32'(dn2 >= 0), 32'd1);
    chk("first_valid1", 32'(fv1), 32'(efv1));
    chk("first_valid2", 32'(fv2), 32'(efv2));
    if (edn1 >= 0) chk("done_cycle1", 32'(dn1), 32'(edn1));
    if (edn2 >= 0) chk("done_cycle2", 32'(dn2), 32'(edn2));
    tick(); tick();
    chk("done_count1", 32'(dcnt1 - d01), 32'd1);
    chk("done_count2", 32'(dcnt2 - d02), 32'd1);
    chk("drained1", 32'(q1.size()), 32'd0);
    chk("drained2", 32'(q2e.size()), 32'd0);
  endtask

  initial begin
    vec_t tbl[6];
    int d01, d02, s1, s2, f1, f2;
    // first-valid at 2+latency; done one cycle after the last of length+1 back-to-back words
    tbl[0] = '{8'h10, 8'd3,   0, 3, 4, 7,   8};
    tbl[1] = '{8'hFE, 8'd3,   0, 3, 4, 7,   8};
    tbl[2] = '{8'h00, 8'd0,   0, 3, 4, 4,   5};
    tbl[3] = '{8'h80, 8'd7,   1, 3, 4, -1, -1};
    tbl[4] = '{8'hC0, 8'd15,  2, 3, 4, -1, -1};
    tbl[5] = '{8'h00, 8'd255, 0, 3, 4, 259, 260};

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; base = '0; len = '0; m_ready = 1'b1;
`ifdef ROM_STREAM_READER_LOOP_EN
    loop = 1'b0;
`endif
    tick(); tick();
    start1 = 1'b1; start2 = 1'b1; base = 8'h33;
    tick();
    start1 = 1'b0; start2 = 1'b0;
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_addr1", 32'(addr1), 32'd0);
    chk("rst_valid1", 32'(mv1), 32'd0);
    chk("rst_data1", 32'(md1), 32'd0);
    chk("rst_last1", 32'(ml1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_burst(tbl[i].base, tbl[i].len, tbl[i].rmode, tbl[i].fv1, tbl[i].fv2, tbl[i].dn1, tbl[i].dn2);
    end

    // Reset in the middle of a stalled burst
    base = 8'h40; len = 8'd7; start1 = 1'b1; start2 = 1'b1; m_ready = 1'b0;
    tick();
    start1 = 1'b0; start2 = 1'b0;
    repeat (5) tick();
    chk("buffered1", 32'(mv1), 32'd1);
    chk("buffered2", 32'(mv2), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid1", 32'(mv1), 32'd0);
    chk("midrst_valid2", 32'(mv2), 32'd0);
    chk("midrst_busy1", 32'(busy1), 32'd0);
    chk("midrst_busy2", 32'(busy2), 32'd0);
    chk("midrst_addr2", 32'(addr2), 32'd0);
    chk("midrst_data2", 32'(md2), 32'd0);
    m_ready = 1'b1;
    repeat (4) tick();
    do_burst(8'h60, 8'd3, 0, 3, 4, 7, 8);

    // Start while busy is ignored; start in the done cycle restarts at once
    d01 = dcnt1; d02 = dcnt2; s1 = -1; s2 = -1; f1 = -1; f2 = -1;
    push_burst(8'h20, 8'd5, 2'b11);
    base = 8'h20; len = 8'd5; start1 = 1'b1; start2 = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        start1 = 1'b0; start2 = 1'b0;
        if (c == 2) begin base = 8'h90; len = 8'd2; start1 = 1'b1; start2 = 1'b1; end
        if (done1 && s1 < 0) begin
          base = 8'h30; len = 8'd2; start1 = 1'b1; s1 = c; push_burst(8'h30, 8'd2, 2'b01);
        end
        if (done2 && s2 < 0) begin
          base = 8'h30; len = 8'd2; start2 = 1'b1; s2 = c; push_burst(8'h30, 8'd2, 2'b10);
        end
        if (s1 >= 0 && f1 < 0 && mv1) f1 = c;
        if (s2 >= 0 && f2 < 0 && mv2) f2 = c;
      end
      tick();
    end
    chk("busy_done_cycle1", 32'(s1), 32'd9);
    chk("busy_done_cycle2", 32'(s2), 32'd10);
    chk("restart_lat1", 32'(f1 - s1), 32'd3);
    chk("restart_lat2", 32'(f2 - s2), 32'd4);
    chk("two_dones1", 32'(dcnt1 - d01), 32'd2);
    chk("two_dones2", 32'(dcnt2 - d02), 32'd2);
    chk("b2_drained1", 32'(q1.size()), 32'd0);
    chk("b2_drained2", 32'(q2e.size()), 32'd0);

`ifdef ROM_STREAM_READER_LOOP_EN
    // Three passes of a two-word burst; loop drops before the third pass end
    d01 = dcnt1; d02 = dcnt2;
    for (int p = 0; p < 3; p++) push_burst(8'h50, 8'd1, 2'b11);
    base = 8'h50; len = 8'd1; loop = 1'b1; start1 = 1'b1; start2 = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin start1 = 1'b0; start2 = 1'b0; end
      if (c >= 5) loop = 1'b0;
      tick();
    end
    chk("loop_done1", 32'(dcnt1 - d01), 32'd1);
    chk("loop_done2", 32'(dcnt2 - d02), 32'd1);
    chk("loop_drained1", 32'(q1.size()), 32'd0);
    chk("loop_drained2", 32'(q2e.size()), 32'd0);
    chk("loop_idle1", 32'(busy1), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
